// File: rtl/uart_pix_packer.sv
// rtl/uart_pix_packer.sv - UART byte stream to RGB565 pixel packer with FWFT pixel FIFO
// Optional per-frame XOR checksum byte and chk_err output: UART_PIX_CHKSUM_EN
module uart_pix_packer #(
  parameter logic [16:0] PIX_COUNT   = 17'd76_800,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] TIMEOUT_CYC = 16'd37_500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        frame_start,
  output logic        frame_done,
  output logic        err_ovf,
  output logic        err_timeout
`ifdef UART_PIX_CHKSUM_EN
  ,
  output logic        chk_err
`endif
);
  localparam int          AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

`ifdef UART_PIX_CHKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DHI, DLO, CHK} state_t;
`else
  typedef enum logic [1:0] {IDLE, HDR, DHI, DLO} state_t;
`endif

  state_t        state;
  logic [7:0]    pix_hi;
  logic [16:0]   pix_cnt;
  logic [15:0]   to_cnt;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic [AW-1:0] rd_idx_next;
  logic          fifo_full;
  logic          in_frame;
  logic          to_hit;
  logic          push_req;
  logic          do_push;
  logic          do_pop;
  logic [15:0]   push_pix;
`ifdef UART_PIX_CHKSUM_EN
  logic [7:0]    chk_acc;
`endif

  // Pointers carry one wrap bit, so the MSB of the difference means full.
  assign fifo_cnt    = wr_ptr - rd_ptr;
  assign fifo_full   = fifo_cnt[AW];
  assign rd_idx_next = rd_ptr[AW-1:0] + 1'b1;
  assign pix_valid   = (fifo_cnt != '0);
  assign do_pop      = pix_valid & pix_ready;
  assign push_req    = rx_valid & (state == DLO);
  assign do_push     = push_req & (~fifo_full | do_pop);
  assign push_pix    = {pix_hi, rx_byte};

`ifdef UART_PIX_CHKSUM_EN
  assign in_frame = (state == DHI) || (state == DLO) || (state == CHK);
`else
  assign in_frame = (state == DHI) || (state == DLO);
`endif
  // A byte arriving in the hit cycle wins over the timeout.
  assign to_hit = in_frame & ~rx_valid & (to_cnt == TIMEOUT_CYC);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Head register: holds its last value while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_data <= '0;
    end else if (do_push && (fifo_cnt == '0 || (fifo_cnt == CNT_ONE && do_pop))) begin
      pix_data <= push_pix;
    end else if (do_pop && fifo_cnt != CNT_ONE) begin
      pix_data <= mem[rd_idx_next];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pix_hi      <= '0;
      pix_cnt     <= '0;
      to_cnt      <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      err_ovf     <= 1'b0;
      err_timeout <= 1'b0;
`ifdef UART_PIX_CHKSUM_EN
      chk_acc     <= '0;
      chk_err     <= 1'b0;
`endif
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;

      if (rx_valid) begin
        to_cnt <= 16'd1;
      end else if (in_frame && to_cnt != TIMEOUT_CYC) begin
        to_cnt <= to_cnt + 16'd1;
      end

      if (push_req && !do_push) err_ovf <= 1'b1;

      if (to_hit) begin
        state       <= IDLE;
        err_timeout <= 1'b1;
      end else if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_byte == 8'hA5) state <= HDR;
          end
          HDR: begin
            if (rx_byte == 8'h5A) begin
              state       <= DHI;
              frame_start <= 1'b1;
              err_ovf     <= 1'b0;
              err_timeout <= 1'b0;
              pix_cnt     <= '0;
`ifdef UART_PIX_CHKSUM_EN
              chk_acc     <= '0;
`endif
            end else if (rx_byte != 8'hA5) begin
              state <= IDLE;
            end
          end
          DHI: begin
            pix_hi <= rx_byte;
            state  <= DLO;
`ifdef UART_PIX_CHKSUM_EN
            chk_acc <= chk_acc ^ rx_byte;
`endif
          end
          DLO: begin
            // Counts dropped pixels too, so frame alignment survives overflow.
            pix_cnt <= pix_cnt + 17'd1;
`ifdef UART_PIX_CHKSUM_EN
            chk_acc <= chk_acc ^ rx_byte;
`endif
            if (pix_cnt == PIX_COUNT - 17'd1) begin
`ifdef UART_PIX_CHKSUM_EN
              state <= CHK;
`else
              state      <= IDLE;
              frame_done <= 1'b1;
`endif
            end else begin
              state <= DHI;
            end
          end
`ifdef UART_PIX_CHKSUM_EN
          CHK: begin
            chk_err    <= (rx_byte != chk_acc);
            frame_done <= 1'b1;
            state      <= IDLE;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
